// File: rtl/rx_polling_ctrl.sv
// rx_polling_ctrl: receive side of LTSSM Polling (Active/Configuration TS1/TS2 counting).
// Ports: Pclk/Reset clock and sync reset; Enable entry request; TS1Valid/TS2Valid/LinkLaneMatch
// received ordered sets; TS2Sent transmitted TS2; TimeOut timer expiry; TimerStart/TimerEnable/
// TimerIntervalCode timer control; SendTS2 Tx select; PollingDone/PollingFail exit pulses; State.
module rx_polling_ctrl #(
    parameter int RX_TS1_COUNT = 8,
    parameter int RX_TS2_COUNT = 8,
    parameter int TX_TS2_COUNT = 16
) (
    input  logic       Pclk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       TS1Valid,
    input  logic       TS2Valid,
    input  logic       LinkLaneMatch,
    input  logic       TS2Sent,
    input  logic       TimeOut,
    output logic       TimerStart,
    output logic       TimerEnable,
    output logic [2:0] TimerIntervalCode,
    output logic       SendTS2,
    output logic       PollingDone,
    output logic       PollingFail,
    output logic [1:0] State
);
    localparam logic [1:0] IDLE = 2'b00, ACTIVE = 2'b01, CONFIG = 2'b10;
    logic [4:0] rx_cnt, tx_cnt, rx_next, tx_next;
    logic       seen, seen_next, go_config, done_now, fail_now;
    function automatic logic [4:0] inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction
    always_comb begin
        rx_next   = (State == ACTIVE)
                  ? ((TS1Valid | TS2Valid) ? (LinkLaneMatch ? inc(rx_cnt) : 5'd0) : rx_cnt)
                  : (TS1Valid ? 5'd0 : TS2Valid ? (LinkLaneMatch ? inc(rx_cnt) : 5'd0) : rx_cnt);
        // the TS2 that sets the sticky flag also unlocks a same-cycle TS2Sent
        seen_next = seen | (TS2Valid & LinkLaneMatch);
        tx_next   = (TS2Sent & seen_next) ? inc(tx_cnt) : tx_cnt;
        go_config = (State == ACTIVE) && (rx_next >= 5'(RX_TS1_COUNT));
        done_now  = (State == CONFIG) && (rx_next >= 5'(RX_TS2_COUNT)) && (tx_next >= 5'(TX_TS2_COUNT));
        // success beats timeout; timeout is blind during the timer restart cycle
        fail_now  = (State != IDLE) && TimeOut && !TimerStart && !go_config && !done_now;
    end
    assign TimerEnable       = (State != IDLE);
    assign SendTS2           = (State == CONFIG);
    assign TimerIntervalCode = (State == ACTIVE) ? 3'b010 : (State == CONFIG) ? 3'b011 : 3'b000;
    always_ff @(posedge Pclk) begin
        if (Reset) begin
            State       <= IDLE;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            seen        <= 1'b0;
            TimerStart  <= 1'b0;
            PollingDone <= 1'b0;
            PollingFail <= 1'b0;
        end else begin
            TimerStart  <= 1'b0;
            PollingDone <= done_now;
            PollingFail <= fail_now;
            if (State == IDLE || State == 2'b11) begin
                State <= IDLE;
                if (Enable) begin
                    State      <= ACTIVE;
                    TimerStart <= 1'b1;
                end
                rx_cnt <= '0;
                tx_cnt <= '0;
                seen   <= 1'b0;
            end else if (go_config) begin
                State      <= CONFIG;
                TimerStart <= 1'b1;
                rx_cnt     <= '0;
                tx_cnt     <= '0;
                seen       <= 1'b0;
            end else if (done_now || fail_now) begin
                State  <= IDLE;
                rx_cnt <= '0;
                tx_cnt <= '0;
                seen   <= 1'b0;
            end else begin
                rx_cnt <= rx_next;
                tx_cnt <= (State == CONFIG) ? tx_next : tx_cnt;
                seen   <= (State == CONFIG) ? seen_next : seen;
            end
        end
    end
endmodule

// File: tb/tb_rx_polling_ctrl.sv
// tb_rx_polling_ctrl: directed self-checking bench for rx_polling_ctrl.
module tb_rx_polling_ctrl;
    logic       Pclk = 1'b0, Reset = 1'b0, Enable = 1'b0, TS1Valid = 1'b0, TS2Valid = 1'b0;
    logic       LinkLaneMatch = 1'b0, TS2Sent = 1'b0, TimeOut = 1'b0;
    logic       TimerStart, TimerEnable, SendTS2, PollingDone, PollingFail;
    logic [2:0] TimerIntervalCode;
    logic [1:0] State;
    int errors = 0, checks = 0;
    // outputs packed as {TimerStart, TimerEnable, TimerIntervalCode, SendTS2, PollingDone, PollingFail}
    localparam logic [7:0] O_IDLE = 8'h00, O_ACT0 = 8'hD0, O_ACT = 8'h50, O_CFG0 = 8'hDC, O_CFG = 8'h5C;
    localparam logic [7:0] O_DONE = 8'h02, O_FAIL = 8'h01;
    rx_polling_ctrl dut (
        .Pclk(Pclk), .Reset(Reset), .Enable(Enable), .TS1Valid(TS1Valid), .TS2Valid(TS2Valid),
        .LinkLaneMatch(LinkLaneMatch), .TS2Sent(TS2Sent), .TimeOut(TimeOut),
        .TimerStart(TimerStart), .TimerEnable(TimerEnable), .TimerIntervalCode(TimerIntervalCode),
        .SendTS2(SendTS2), .PollingDone(PollingDone), .PollingFail(PollingFail), .State(State)
    );
    always #5 Pclk = ~Pclk;
    task automatic tick(input logic rst, en, t1, t2, m, s, to);
        {Reset, Enable, TS1Valid, TS2Valid, LinkLaneMatch, TS2Sent, TimeOut} = {rst, en, t1, t2, m, s, to};
        @(posedge Pclk);
        #1;
        {Reset, Enable, TS1Valid, TS2Valid, LinkLaneMatch, TS2Sent, TimeOut} = '0;
    endtask
    task automatic chk(input string tag, input logic [1:0] st, input logic [7:0] o);
        checks++;
        assert (State === st) else begin
            errors++;
            $error("FAIL %s state: got %b expected %b", tag, State, st);
        end
        checks++;
        assert ({TimerStart, TimerEnable, TimerIntervalCode, SendTS2, PollingDone, PollingFail} === o) else begin
            errors++;
            $error("FAIL %s outputs: got %h expected %h", tag,
                   {TimerStart, TimerEnable, TimerIntervalCode, SendTS2, PollingDone, PollingFail}, o);
        end
    endtask
    initial begin
        @(posedge Pclk); #1;
        tick(1, 0, 0, 0, 0, 0, 0); chk("reset", 2'b00, O_IDLE);
        tick(0, 0, 0, 0, 0, 0, 1); chk("idle_timeout_ignored", 2'b00, O_IDLE);
        // Enable then 8 matching TS1
        tick(0, 1, 0, 0, 0, 0, 0); chk("enter_active", 2'b01, O_ACT0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 1, 0, 0);
        chk("active_7_ts1", 2'b01, O_ACT);
        tick(0, 0, 1, 0, 1, 0, 0); chk("enter_config", 2'b10, O_CFG0);
        tick(0, 1, 0, 0, 0, 0, 0); chk("config_enable_ignored", 2'b10, O_CFG);
        // TS2Sent before first TS2 does not count; first TS2 counts its own TS2Sent
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 1, 1, 0);
        chk("config_rx8_tx8", 2'b10, O_CFG);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 0, 1, 0);
        chk("config_tx15", 2'b10, O_CFG);
        tick(0, 0, 0, 0, 0, 1, 0); chk("polling_done", 2'b00, O_DONE);
        tick(0, 0, 0, 0, 0, 0, 0); chk("done_one_cycle", 2'b00, O_IDLE);
        // ACTIVE: non-matching TS resets the run
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 1, 0, 0);
        chk("active_mismatch_reset", 2'b01, O_ACT);
        tick(0, 0, 0, 1, 1, 0, 0); chk("active_8th_consecutive", 2'b10, O_CFG0);
        // reset mid-CONFIG with rx=5, tx=10, plus Enable and TimeOut asserted
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 1, 0);
        chk("config_rx5_tx10", 2'b10, O_CFG);
        tick(1, 1, 1, 1, 1, 1, 1); chk("reset_mid_config", 2'b00, O_IDLE);
        tick(0, 0, 0, 0, 0, 0, 0); chk("reset_stays_idle", 2'b00, O_IDLE);
        // re-entry needs full counts again
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 1, 0, 0);
        chk("reentry_active_7", 2'b01, O_ACT);
        tick(0, 0, 1, 0, 1, 0, 0); chk("reentry_config", 2'b10, O_CFG0);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 0, 1, 0);
        chk("reentry_rx7_tx16", 2'b10, O_CFG);
        tick(0, 0, 1, 0, 1, 0, 0); chk("config_ts1_clears_rx", 2'b10, O_CFG);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 1, 1, 0, 0);
        chk("config_rx7_after_clear", 2'b10, O_CFG);
        tick(0, 0, 0, 1, 1, 0, 0); chk("reentry_done", 2'b00, O_DONE);
        // timeout: ignored in TimerStart cycle, otherwise fails
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1); chk("active_timeout_in_start", 2'b01, O_ACT);
        tick(0, 0, 0, 0, 0, 0, 1); chk("active_timeout_fail", 2'b00, O_FAIL);
        tick(0, 0, 0, 0, 0, 0, 0); chk("fail_one_cycle", 2'b00, O_IDLE);
        // success beats coincident timeout
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 1, 0, 1); chk("timeout_vs_8th_ts1", 2'b10, O_CFG0);
        tick(0, 0, 0, 0, 0, 0, 1); chk("config_timeout_in_start", 2'b10, O_CFG);
        tick(0, 0, 0, 0, 0, 0, 1); chk("config_timeout_fail", 2'b00, O_FAIL);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
